// File: rtl/apb_master_arbiter_if.sv
// Bundle of the two requester handshakes and the APB master bus used by apb_master_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_master_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req0_valid_i;
  logic                  req0_write_i;
  logic [ADDR_WIDTH-1:0] req0_addr_i;
  logic [DATA_WIDTH-1:0] req0_wdata_i;
  logic [STRB_WIDTH-1:0] req0_strb_i;
  logic                  req0_ready_o;
  logic                  req0_done_o;
  logic [DATA_WIDTH-1:0] req0_rdata_o;
  logic                  req0_err_o;

  logic                  req1_valid_i;
  logic                  req1_write_i;
  logic [ADDR_WIDTH-1:0] req1_addr_i;
  logic [DATA_WIDTH-1:0] req1_wdata_i;
  logic [STRB_WIDTH-1:0] req1_strb_i;
  logic                  req1_ready_o;
  logic                  req1_done_o;
  logic [DATA_WIDTH-1:0] req1_rdata_o;
  logic                  req1_err_o;

  logic [ADDR_WIDTH-1:0] PADDR_o;
  logic                  PWRITE_o;
  logic [DATA_WIDTH-1:0] PWDATA_o;
  logic [STRB_WIDTH-1:0] PSTRB_o;
  logic                  PSEL_o;
  logic                  PENABLE_o;
  logic [DATA_WIDTH-1:0] PRDATA_i;
  logic                  PREADY_i;
  logic                  PSLVERR_i;

  modport master (
    input  req0_valid_i, req0_write_i, req0_addr_i, req0_wdata_i, req0_strb_i,
    output req0_ready_o, req0_done_o, req0_rdata_o, req0_err_o,
    input  req1_valid_i, req1_write_i, req1_addr_i, req1_wdata_i, req1_strb_i,
    output req1_ready_o, req1_done_o, req1_rdata_o, req1_err_o,
    output PADDR_o, PWRITE_o, PWDATA_o, PSTRB_o, PSEL_o, PENABLE_o,
    input  PRDATA_i, PREADY_i, PSLVERR_i
  );

  modport slave (
    output req0_valid_i, req0_write_i, req0_addr_i, req0_wdata_i, req0_strb_i,
    input  req0_ready_o, req0_done_o, req0_rdata_o, req0_err_o,
    output req1_valid_i, req1_write_i, req1_addr_i, req1_wdata_i, req1_strb_i,
    input  req1_ready_o, req1_done_o, req1_rdata_o, req1_err_o,
    input  PADDR_o, PWRITE_o, PWDATA_o, PSTRB_o, PSEL_o, PENABLE_o,
    output PRDATA_i, PREADY_i, PSLVERR_i
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by two valid/ready requesters, with a PREADY timeout
// so a stalled slave terminates the transfer with an error instead of locking the bus.
module apb_master_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int TIMEOUT    = 16
) (
  input logic                  PCLK_i,
  input logic                  PRESETn_i,
  apb_master_arbiter_if.master bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_owner;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_done0, r_done1;
  logic                  r_err0, r_err1;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;

  logic                  w_gnt0, w_gnt1, w_acc;
  logic                  w_acc_write;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [DATA_WIDTH-1:0] w_acc_wdata;
  logic [STRB_WIDTH-1:0] w_acc_strb;
  logic                  w_timeout, w_cpl, w_cpl_err;
  logic [DATA_WIDTH-1:0] w_cpl_rdata;

  // Grant only in IDLE; on contention the port that did not win last time goes first.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = !r_last_grant;
      end else begin
        w_gnt0 = bus.req0_valid_i;
        w_gnt1 = bus.req1_valid_i;
      end
    end
    w_acc       = w_gnt0 | w_gnt1;
    w_acc_write = w_gnt1 ? bus.req1_write_i : bus.req0_write_i;
    w_acc_addr  = w_gnt1 ? bus.req1_addr_i  : bus.req0_addr_i;
    w_acc_wdata = w_gnt1 ? bus.req1_wdata_i : bus.req0_wdata_i;
    w_acc_strb  = w_gnt1 ? bus.req1_strb_i  : bus.req0_strb_i;
  end

  // A high PREADY in the last allowed cycle still completes normally.
  always_comb begin
    w_timeout   = !bus.PREADY_i && (r_cnt == 8'(TIMEOUT - 1));
    w_cpl       = (r_state == ACCESS) && (bus.PREADY_i || w_timeout);
    w_cpl_rdata = (bus.PREADY_i && !r_pwrite) ? bus.PRDATA_i : '0;
    w_cpl_err   = bus.PREADY_i ? bus.PSLVERR_i : 1'b1;
  end

  always_ff @(posedge PCLK_i) begin
    if (!PRESETn_i) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_paddr      <= w_acc_addr;
            r_pwrite     <= w_acc_write;
            r_pwdata     <= w_acc_wdata;
            r_pstrb      <= w_acc_write ? w_acc_strb : '0;
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_psel       <= 1'b1;
            r_state      <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_cpl) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            r_state   <= IDLE;
            if (r_owner) begin
              r_done1  <= 1'b1;
              r_rdata1 <= w_cpl_rdata;
              r_err1   <= w_cpl_err;
            end else begin
              r_done0  <= 1'b1;
              r_rdata0 <= w_cpl_rdata;
              r_err0   <= w_cpl_err;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready_o = w_gnt0;
  assign bus.req1_ready_o = w_gnt1;
  assign bus.req0_done_o  = r_done0;
  assign bus.req1_done_o  = r_done1;
  assign bus.req0_rdata_o = r_rdata0;
  assign bus.req1_rdata_o = r_rdata1;
  assign bus.req0_err_o   = r_err0;
  assign bus.req1_err_o   = r_err1;
  assign bus.PADDR_o      = r_paddr;
  assign bus.PWRITE_o     = r_pwrite;
  assign bus.PWDATA_o     = r_pwdata;
  assign bus.PSTRB_o      = r_pstrb;
  assign bus.PSEL_o       = r_psel;
  assign bus.PENABLE_o    = r_penable;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized scoreboard bench for apb_master_arbiter: a transaction-level model predicts
// grants, completion cycles and results; a separate monitor compares DUT outputs to it.
module tb_apb_master_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = 4;
  localparam int T  = 4;

  typedef struct { int port; logic [DW-1:0] rdata; logic err; int d; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; logic [SW-1:0] strb; int s; int e; } apb_t;
  typedef struct { int w; logic e; } plan_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  apb_master_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_master_arbiter #(.DATA_WIDTH(DW), .DEPTH(1024), .TIMEOUT(T)) dut (
    .PCLK_i   (clk),
    .PRESETn_i(rstn),
    .bus      (bus)
  );

  logic          v[2], wr[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wd[2];
  logic [SW-1:0] st[2];
  logic          p_ready, p_err;
  logic [DW-1:0] p_rdata;

  assign bus.req0_valid_i = v[0];
  assign bus.req0_write_i = wr[0];
  assign bus.req0_addr_i  = addr[0];
  assign bus.req0_wdata_i = wd[0];
  assign bus.req0_strb_i  = st[0];
  assign bus.req1_valid_i = v[1];
  assign bus.req1_write_i = wr[1];
  assign bus.req1_addr_i  = addr[1];
  assign bus.req1_wdata_i = wd[1];
  assign bus.req1_strb_i  = st[1];
  assign bus.PREADY_i     = p_ready;
  assign bus.PSLVERR_i    = p_err;
  assign bus.PRDATA_i     = p_rdata;

  logic          done_w[2], err_w[2];
  logic [DW-1:0] rdata_w[2];
  assign done_w[0]  = bus.req0_done_o;
  assign done_w[1]  = bus.req1_done_o;
  assign err_w[0]   = bus.req0_err_o;
  assign err_w[1]   = bus.req1_err_o;
  assign rdata_w[0] = bus.req0_rdata_o;
  assign rdata_w[1] = bus.req1_rdata_o;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  apb_t  apb_q[$];
  plan_t plan_q[$];

  logic [DW-1:0] ref_mem[1024];
  logic [DW-1:0] smem[1024];

  // model / driver state
  int   busy_until = 0;
  int   last_g = 1;
  int   mode = 0;
  bit   acc[2], nxt_set[2], f_en[2], chk_en = 0;
  int   f_w[2], nacc[2];
  logic f_e[2], nxt_wr[2];
  logic [AW-1:0] nxt_addr[2];
  logic [DW-1:0] nxt_wd[2];
  logic [SW-1:0] nxt_st[2];
  logic [DW-1:0] hold_rd[2];
  logic          hold_er[2];
  apb_t mon_cur;
  bit   mon_cur_v = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic new_rand(input int n);
    v[n]    = 1'b1;
    wr[n]   = 1'($urandom_range(0, 1));
    addr[n] = $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 1023));
    wd[n]   = $urandom;
    st[n]   = SW'($urandom_range(0, 15));
  endtask

  task automatic put(input int n, input logic w_, input logic [AW-1:0] a_, input logic [DW-1:0] d_,
                     input logic [SW-1:0] s_, input int pw, input logic pe);
    nxt_wr[n] = w_; nxt_addr[n] = a_; nxt_wd[n] = d_; nxt_st[n] = s_;
    nxt_set[n] = 1'b1;
    f_en[n] = (pw >= 0);
    f_w[n]  = pw;
    f_e[n]  = pe;
  endtask

  task automatic accept(input int n);
    plan_t p;
    exp_t  x;
    apb_t  y;
    int    a, r;
    bit    to;
    a = cyc;
    if (f_en[n]) begin
      p.w = f_w[n]; p.e = f_e[n]; f_en[n] = 1'b0;
    end else begin
      r = $urandom_range(0, 9);
      p.w = (r < 4) ? 0 : (r < 8) ? $urandom_range(1, 3) : $urandom_range(4, 6);
      p.e = ($urandom_range(0, 5) == 0);
    end
    to = (p.w >= T);
    x.port = n;
    x.d = to ? a + 2 + T : a + 3 + p.w;
    if (to) begin
      x.rdata = '0; x.err = 1'b1;
    end else begin
      x.err = p.e;
      x.rdata = wr[n] ? '0 : ref_mem[addr[n]];
      if (wr[n] && !p.e)
        for (int b = 0; b < SW; b++)
          if (st[n][b]) ref_mem[addr[n]][8*b +: 8] = wd[n][8*b +: 8];
    end
    y.addr = addr[n]; y.wr = wr[n]; y.wdata = wd[n];
    y.strb = wr[n] ? st[n] : '0;
    y.s = a + 1; y.e = x.d - 1;
    exp_q.push_back(x);
    apb_q.push_back(y);
    plan_q.push_back(p);
    busy_until = x.d;
    last_g = n;
    acc[n] = 1'b1;
    nacc[n]++;
  endtask

  task automatic step();
    int  win;
    bit  idle, any;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        acc[n] = 1'b0;
        if (mode == 2 && $urandom_range(0, 1) == 1) new_rand(n);
        else if (mode != 1) v[n] = 1'b0;
      end else if (mode == 2 && !v[n] && $urandom_range(0, 3) == 0) begin
        new_rand(n);
      end
      if (nxt_set[n]) begin
        v[n] = 1'b1; wr[n] = nxt_wr[n]; addr[n] = nxt_addr[n]; wd[n] = nxt_wd[n]; st[n] = nxt_st[n];
        nxt_set[n] = 1'b0;
      end
    end
    #1;
    idle = (cyc >= busy_until);
    any  = v[0] || v[1];
    win  = (v[0] && v[1]) ? 1 - last_g : (v[0] ? 0 : 1);
    chk("ready0", bus.req0_ready_o, idle && any && win == 0);
    chk("ready1", bus.req1_ready_o, idle && any && win == 1);
    if (idle && any) accept(win);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((v[0] || v[1] || acc[0] || acc[1] || nxt_set[0] || nxt_set[1] || cyc <= busy_until) && k < 400) begin
      step();
      k++;
    end
    if (k >= 400) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy expected idle within 400 cycles (cycle %0d)", cyc);
    end
  endtask

  // slave model: plan popped at SETUP, PREADY after planned waits, byte-strobed writes
  initial begin
    int    bk;
    plan_t cur;
    bk = 0; cur.w = 0; cur.e = 1'b0;
    p_ready = 1'b0; p_err = 1'b0; p_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.PSEL_o && !bus.PENABLE_o) begin
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else begin cur.w = 0; cur.e = 1'b0; end
        bk = 0; p_ready = 1'b0; p_err = 1'($urandom_range(0, 1)); p_rdata = $urandom;
      end else if (bus.PSEL_o && bus.PENABLE_o) begin
        if (cur.w < T && bk == cur.w) begin
          p_ready = 1'b1;
          p_err   = cur.e;
          p_rdata = bus.PWRITE_o ? $urandom : smem[bus.PADDR_o];
          if (bus.PWRITE_o && !cur.e)
            for (int b = 0; b < SW; b++)
              if (bus.PSTRB_o[b]) smem[bus.PADDR_o][8*b +: 8] = bus.PWDATA_o[8*b +: 8];
        end else begin
          p_ready = 1'b0; p_err = 1'($urandom_range(0, 1)); p_rdata = $urandom;
        end
        bk++;
      end else begin
        p_ready = 1'b0; p_err = 1'b0; p_rdata = $urandom;
      end
    end
  end

  // monitor: completions, held results and APB phase/field stability
  initial begin
    bit dn, want, ep, ee;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        dn = (exp_q.size() > 0) && (exp_q[0].d == cyc);
        for (int n = 0; n < 2; n++) begin
          want = dn && (exp_q[0].port == n);
          chk($sformatf("done%0d", n), done_w[n], want);
          if (want) begin
            chk($sformatf("rdata%0d", n), rdata_w[n], exp_q[0].rdata);
            chk($sformatf("err%0d", n), err_w[n], exp_q[0].err);
            hold_rd[n] = exp_q[0].rdata;
            hold_er[n] = exp_q[0].err;
          end else if (!done_w[n]) begin
            chk($sformatf("hold_rdata%0d", n), rdata_w[n], hold_rd[n]);
            chk($sformatf("hold_err%0d", n), err_w[n], hold_er[n]);
          end
        end
        if (dn) void'(exp_q.pop_front());
        if (apb_q.size() > 0 && apb_q[0].s == cyc) begin
          mon_cur = apb_q.pop_front();
          mon_cur_v = 1'b1;
        end
        ep = mon_cur_v && cyc >= mon_cur.s && cyc <= mon_cur.e;
        ee = mon_cur_v && cyc > mon_cur.s && cyc <= mon_cur.e;
        chk("PSEL", bus.PSEL_o, ep);
        chk("PENABLE", bus.PENABLE_o, ee);
        if (ep) begin
          chk("PADDR", bus.PADDR_o, mon_cur.addr);
          chk("PWRITE", bus.PWRITE_o, mon_cur.wr);
          chk("PWDATA", bus.PWDATA_o, mon_cur.wdata);
          chk("PSTRB", bus.PSTRB_o, mon_cur.strb);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, k;
    for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; smem[i] = '0; end
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; wr[n] = 1'b0; addr[n] = '0; wd[n] = '0; st[n] = '0;
      acc[n] = 1'b0; nxt_set[n] = 1'b0; f_en[n] = 1'b0; nacc[n] = 0;
      hold_rd[n] = '0; hold_er[n] = 1'b0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_psel", bus.PSEL_o, 1'b0);
    chk("rst_penable", bus.PENABLE_o, 1'b0);
    chk("rst_ready0", bus.req0_ready_o, 1'b0);
    chk("rst_ready1", bus.req1_ready_o, 1'b0);
    chk("rst_done0", bus.req0_done_o, 1'b0);
    chk("rst_done1", bus.req1_done_o, 1'b0);
    chk("rst_rdata0", bus.req0_rdata_o, '0);
    chk("rst_rdata1", bus.req1_rdata_o, '0);
    chk("rst_err0", bus.req0_err_o, 1'b0);
    chk("rst_err1", bus.req1_err_o, 1'b0);
    rstn = 1'b1;
    chk_en = 1'b1;

    // single write then read-back
    put(0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    wait_idle();
    put(0, 1'b0, 10'h005, 32'h0, 4'h0, 0, 1'b0);
    wait_idle();

    // both ports requesting continuously
    mode = 1;
    b0 = nacc[0]; b1 = nacc[1];
    put(0, 1'b1, 10'h010, 32'h0BADF00D, 4'hF, -1, 1'b0);
    put(1, 1'b0, 10'h005, 32'h0, 4'hF, -1, 1'b0);
    k = 0;
    while ((nacc[0] < b0 + 4 || nacc[1] < b1 + 4) && k < 300) begin step(); k++; end
    chk("rr_grants0", (nacc[0] - b0 >= 4), 1'b1);
    chk("rr_grants1", (nacc[1] - b1 >= 4), 1'b1);
    mode = 0;
    wait_idle();

    // wait states, timeout, recovery, last-chance ready, slave error
    put(0, 1'b1, 10'h020, 32'h12345678, 4'h5, 3, 1'b0);
    wait_idle();
    put(1, 1'b0, 10'h005, 32'h0, 4'h0, 6, 1'b0);
    wait_idle();
    put(1, 1'b0, 10'h005, 32'h0, 4'h0, 0, 1'b0);
    wait_idle();
    put(0, 1'b0, 10'h020, 32'h0, 4'h0, T - 1, 1'b0);
    wait_idle();
    put(0, 1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    wait_idle();
    put(1, 1'b0, 10'h3FF, 32'h0, 4'h0, 0, 1'b1);
    wait_idle();

    // random traffic
    mode = 2;
    repeat (3000) step();
    mode = 0;
    wait_idle();

    // reset during ACCESS
    put(1, 1'b0, 10'h123, 32'h0, 4'h0, 3, 1'b0);
    k = 0;
    while (!acc[1] && k < 30) begin step(); k++; end
    chk("rstmid_accept", acc[1], 1'b1);
    step();
    step();
    chk("rstmid_psel_access", bus.PSEL_o, 1'b1);
    chk("rstmid_pen_access", bus.PENABLE_o, 1'b1);
    chk_en = 1'b0;
    exp_q.delete(); apb_q.delete(); plan_q.delete();
    mon_cur_v = 1'b0;
    last_g = 1; busy_until = 0;
    for (int n = 0; n < 2; n++) begin hold_rd[n] = '0; hold_er[n] = 1'b0; end
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid_psel", bus.PSEL_o, 1'b0);
    chk("rstmid_penable", bus.PENABLE_o, 1'b0);
    chk("rstmid_done0", bus.req0_done_o, 1'b0);
    chk("rstmid_done1", bus.req1_done_o, 1'b0);
    rstn = 1'b1;
    chk_en = 1'b1;
    put(0, 1'b0, 10'h005, 32'h0, 4'h0, 0, 1'b0);
    put(1, 1'b0, 10'h006, 32'h0, 4'h0, 0, 1'b0);
    step();
    chk("rstmid_prio_port0", acc[0], 1'b1);
    wait_idle();
    repeat (8) step();

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
